// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// Double-buffered BCD value, committed at frame wrap; optional leading-zero blanking.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int GUARD_CYCLES = 2,
    parameter int DRIVE_CYCLES = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_bcd,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [3:0]              digit,
    output logic                    frame_start
);

    localparam int CNT_MAX = (GUARD_CYCLES > DRIVE_CYCLES) ? GUARD_CYCLES : DRIVE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [4*NUM_DIGITS-1:0] ALL_BLANK = {NUM_DIGITS{4'hF}};

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic                    pending_q, pending_d;
    logic                    frame_start_q, frame_start_d;
    logic                    blank_lz_q, blank_lz_d;

    logic [3:0]              disp_sel;
    logic [3:0]              nib;
    logic                    zeros_above;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_GUARD;
            cnt_q         <= '0;
            idx_q         <= '0;
            active_q      <= ALL_BLANK;
            shadow_q      <= '0;
            pending_q     <= 1'b0;
            frame_start_q <= 1'b0;
            blank_lz_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            pending_q     <= pending_d;
            frame_start_q <= frame_start_d;
            blank_lz_q    <= blank_lz_d;
        end
    end

    // Scan sequencing; the shadow is committed only when the scan wraps to digit 0.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        active_d      = active_q;
        shadow_d      = shadow_q;
        pending_d     = pending_q;
        frame_start_d = 1'b0;
        blank_lz_d    = blank_lz;

        case (state_q)
            ST_GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DRIVE: begin
                if (cnt_q == DRIVE_LAST) begin
                    state_d = ST_GUARD;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d         = '0;
                        frame_start_d = 1'b1;
                        if (pending_q) begin
                            active_d  = shadow_q;
                            pending_d = 1'b0;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_GUARD;
                cnt_d   = '0;
            end
        endcase

        // An accept needs pending=0, so it can never collide with a commit above.
        if (load_valid && !pending_q) begin
            shadow_d  = value_bcd;
            pending_d = 1'b1;
        end
    end

    // Walk from the top digit down so zeros_above covers nibbles i..NUM_DIGITS-1.
    always_comb begin
        zeros_above = 1'b1;
        disp_sel    = 4'hF;
        nib         = 4'h0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib         = active_q[4*i +: 4];
            zeros_above = zeros_above && (nib == 4'h0);
            if (idx_q == IDX_W'(i)) begin
                disp_sel = (blank_lz_q && zeros_above && (i != 0)) ? 4'hF : nib;
            end
        end
    end

    always_comb begin
        an    = '0;
        digit = 4'hF;
        if (state_q == ST_DRIVE) begin
            an    = NUM_DIGITS'(1) << idx_q;
            digit = disp_sel;
        end
    end

    assign load_ready  = !pending_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed self-checking bench for seven_seg_scan_ctrl (4 digits, guard 2, drive 5).
// Timing vectors are table driven; handshake and reset corner cases are hand sequenced.
module tb_seven_seg_scan_ctrl;

    localparam int FRAME = 28;

    logic        clk;
    logic        rst;
    logic [15:0] value_bcd;
    logic        load_valid;
    logic        load_ready;
    logic        blank_lz;
    logic [3:0]  an;
    logic [3:0]  digit;
    logic        frame_start;

    int tests_run;
    int tests_failed;
    int cyc;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [3:0] digit;
        logic       fs;
        logic       rdy;
        logic       rdy_chk;
    } scan_vec_t;

    typedef struct {
        logic [15:0] value;
        logic        blz;
        logic [15:0] exp;
    } lz_vec_t;

    scan_vec_t vec_idle[13];
    scan_vec_t vec_load[13];
    lz_vec_t   vec_lz[9];

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .GUARD_CYCLES(2),
        .DRIVE_CYCLES(5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value_bcd  (value_bcd),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .blank_lz   (blank_lz),
        .an         (an),
        .digit      (digit),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic advance_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        load_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        cyc = 0;
    endtask

    task automatic apply_vectors(input string tag, input scan_vec_t v);
        advance_to(v.cyc);
        check_output({tag, "_an"}, {12'h0, an}, {12'h0, v.an});
        check_output({tag, "_digit"}, {12'h0, digit}, {12'h0, v.digit});
        check_output({tag, "_fs"}, {15'h0, frame_start}, {15'h0, v.fs});
        if (v.rdy_chk) check_output({tag, "_ready"}, {15'h0, load_ready}, {15'h0, v.rdy});
    endtask

    // Waits for the shadow to be free, loads v, then waits for the wrap that commits it.
    task automatic load_and_commit(input logic [15:0] v);
        int n;
        n = 0;
        while (load_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check_output("ready_wait", {15'h0, load_ready}, 16'h1);
        value_bcd  = v;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        check_output("ready_after_accept", {15'h0, load_ready}, 16'h0);
        n = 0;
        do begin
            tick();
            n++;
        end while (frame_start !== 1'b1 && n < 200);
        check_output("fs_wait", {15'h0, frame_start}, 16'h1);
    endtask

    // Records the digit shown under each anode over one frame, starting at the current cycle.
    task automatic capture_frame(output logic [15:0] got, output logic [3:0] seen);
        got  = 16'h0;
        seen = 4'h0;
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) tick();
            case (an)
                4'b0001: begin got[3:0]   = digit; seen[0] = 1'b1; end
                4'b0010: begin got[7:4]   = digit; seen[1] = 1'b1; end
                4'b0100: begin got[11:8]  = digit; seen[2] = 1'b1; end
                4'b1000: begin got[15:12] = digit; seen[3] = 1'b1; end
                default: ;
            endcase
        end
    endtask

    initial begin
        logic [15:0] got;
        logic [3:0]  seen;
        int          fs_count;
        logic        release_next;
        logic        done;

        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        rst          = 1'b1;
        load_valid   = 1'b0;
        value_bcd    = 16'h0;
        blank_lz     = 1'b0;

        vec_idle[0]  = '{0,  4'b0000, 4'hF, 1'b0, 1'b1, 1'b1};
        vec_idle[1]  = '{1,  4'b0000, 4'hF, 1'b0, 1'b1, 1'b1};
        vec_idle[2]  = '{2,  4'b0001, 4'hF, 1'b0, 1'b1, 1'b1};
        vec_idle[3]  = '{6,  4'b0001, 4'hF, 1'b0, 1'b1, 1'b1};
        vec_idle[4]  = '{7,  4'b0000, 4'hF, 1'b0, 1'b1, 1'b1};
        vec_idle[5]  = '{9,  4'b0010, 4'hF, 1'b0, 1'b1, 1'b1};
        vec_idle[6]  = '{13, 4'b0010, 4'hF, 1'b0, 1'b1, 1'b1};
        vec_idle[7]  = '{16, 4'b0100, 4'hF, 1'b0, 1'b1, 1'b1};
        vec_idle[8]  = '{23, 4'b1000, 4'hF, 1'b0, 1'b1, 1'b1};
        vec_idle[9]  = '{27, 4'b1000, 4'hF, 1'b0, 1'b1, 1'b1};
        vec_idle[10] = '{28, 4'b0000, 4'hF, 1'b1, 1'b1, 1'b1};
        vec_idle[11] = '{29, 4'b0000, 4'hF, 1'b0, 1'b1, 1'b1};
        vec_idle[12] = '{30, 4'b0001, 4'hF, 1'b0, 1'b1, 1'b1};

        vec_load[0]  = '{4,  4'b0001, 4'hF, 1'b0, 1'b0, 1'b1};
        vec_load[1]  = '{27, 4'b1000, 4'hF, 1'b0, 1'b0, 1'b1};
        vec_load[2]  = '{28, 4'b0000, 4'hF, 1'b1, 1'b1, 1'b0};
        vec_load[3]  = '{29, 4'b0000, 4'hF, 1'b0, 1'b1, 1'b1};
        vec_load[4]  = '{30, 4'b0001, 4'h4, 1'b0, 1'b1, 1'b1};
        vec_load[5]  = '{34, 4'b0001, 4'h4, 1'b0, 1'b1, 1'b1};
        vec_load[6]  = '{35, 4'b0000, 4'hF, 1'b0, 1'b1, 1'b1};
        vec_load[7]  = '{37, 4'b0010, 4'h3, 1'b0, 1'b1, 1'b1};
        vec_load[8]  = '{44, 4'b0100, 4'h2, 1'b0, 1'b1, 1'b1};
        vec_load[9]  = '{51, 4'b1000, 4'h1, 1'b0, 1'b1, 1'b1};
        vec_load[10] = '{55, 4'b1000, 4'h1, 1'b0, 1'b1, 1'b1};
        vec_load[11] = '{56, 4'b0000, 4'hF, 1'b1, 1'b1, 1'b1};
        vec_load[12] = '{58, 4'b0001, 4'h4, 1'b0, 1'b1, 1'b1};

        vec_lz[0] = '{16'h0070, 1'b1, 16'hFF70};
        vec_lz[1] = '{16'h0000, 1'b1, 16'hFFF0};
        vec_lz[2] = '{16'h0000, 1'b0, 16'h0000};
        vec_lz[3] = '{16'h0070, 1'b0, 16'h0070};
        vec_lz[4] = '{16'hA0F9, 1'b0, 16'hA0F9};
        vec_lz[5] = '{16'hA0F9, 1'b1, 16'hA0F9};
        vec_lz[6] = '{16'h0100, 1'b1, 16'hF100};
        vec_lz[7] = '{16'h1234, 1'b1, 16'h1234};
        vec_lz[8] = '{16'h0009, 1'b1, 16'hFFF9};

        // Outputs while reset is held
        @(posedge clk);
        @(negedge clk);
        check_output("rst_an", {12'h0, an}, 16'h0);
        check_output("rst_digit", {12'h0, digit}, 16'h000F);
        check_output("rst_ready", {15'h0, load_ready}, 16'h1);
        check_output("rst_fs", {15'h0, frame_start}, 16'h0);

        // Idle scan after reset, no load
        do_reset();
        for (int i = 0; i < 13; i++) apply_vectors("idle", vec_idle[i]);

        do_reset();
        fs_count = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) tick();
            if (frame_start === 1'b1) fs_count++;
        end
        check_output("first_frame_no_fs", fs_count[15:0], 16'h0);

        // Load 1234 at cycle 3, committed at the first wrap
        do_reset();
        advance_to(3);
        check_output("load_ready_c3", {15'h0, load_ready}, 16'h1);
        value_bcd  = 16'h1234;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 13; i++) apply_vectors("load", vec_load[i]);

        // Digit codes and leading-zero blanking
        do_reset();
        for (int i = 0; i < 9; i++) begin
            blank_lz = vec_lz[i].blz;
            load_and_commit(vec_lz[i].value);
            capture_frame(got, seen);
            check_output("lz_frame", got, vec_lz[i].exp);
            check_output("lz_seen", {12'h0, seen}, 16'h000F);
        end
        blank_lz = 1'b0;

        // Valid held while not ready: second value waits for ready
        do_reset();
        advance_to(3);
        value_bcd  = 16'h1111;
        load_valid = 1'b1;
        tick();
        value_bcd = 16'h2222;
        check_output("hold_ready_c4", {15'h0, load_ready}, 16'h0);
        release_next = 1'b0;
        done         = 1'b0;
        while (cyc < 56) begin
            tick();
            if (release_next) begin
                load_valid   = 1'b0;
                release_next = 1'b0;
                done         = 1'b1;
            end else if (!done && load_ready === 1'b1) begin
                release_next = 1'b1;
            end
            if (cyc == 30 || cyc == 37 || cyc == 44 || cyc == 51)
                check_output("hold_frame2_digit", {12'h0, digit}, 16'h0001);
        end
        load_valid = 1'b0;
        check_output("hold_accepted", {15'h0, done}, 16'h1);
        check_output("hold_fs_c56", {15'h0, frame_start}, 16'h1);
        capture_frame(got, seen);
        check_output("hold_frame3", got, 16'h2222);

        // Reset at cycle 15 with a pending value discards it
        do_reset();
        advance_to(3);
        value_bcd  = 16'h5678;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        advance_to(15);
        check_output("pre_rst_ready", {15'h0, load_ready}, 16'h0);
        rst = 1'b1;
        tick();
        check_output("midrst_an", {12'h0, an}, 16'h0);
        check_output("midrst_digit", {12'h0, digit}, 16'h000F);
        check_output("midrst_ready", {15'h0, load_ready}, 16'h1);
        rst = 1'b0;
        cyc = 0;
        advance_to(FRAME);
        check_output("midrst_fs", {15'h0, frame_start}, 16'h1);
        capture_frame(got, seen);
        check_output("midrst_blank", got, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
